// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back queue.
// Optional feature macro used by the top: WB_BYPASS_EN (read-bypass lookup).
package wb_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] regidx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending register writes. The head entry (rd pointer) is the
// one currently presented to the bank; per-entry valid bits support bypass scans.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_enq,
    input  wb_entry_t             i_entry,
    input  logic                  i_deq,
    output wb_entry_t [DEPTH-1:0] o_mem,
    output logic      [DEPTH-1:0] o_valid,
    output logic      [PW-1:0]    o_rd_ptr,
    output logic      [PW:0]      o_count,
    output wb_entry_t             o_second
);

    wb_entry_t [DEPTH-1:0] r_mem;
    logic      [DEPTH-1:0] r_valid;
    logic      [PW-1:0]    r_rd_ptr;
    logic      [PW-1:0]    r_wr_ptr;
    logic      [PW:0]      r_count;

    // Storage, pointers and occupancy; flush empties the buffer outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_valid  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_valid  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_enq) begin
                r_mem[r_wr_ptr]   <= i_entry;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            if (i_deq) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PW'(1);
            end
            case ({i_enq, i_deq})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_mem    = r_mem;
    assign o_valid  = r_valid;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;
    assign o_second = r_mem[r_rd_ptr + PW'(1)];

endmodule

// File: rtl/writeback_queue.sv
// Write-back queue: buffers results and drives the register bank write port one
// write per cycle, absorbing bank stalls and discarding writes to r0.
// Build option: define WB_BYPASS_EN to enable read-bypass lookup from queued entries.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [ADDR_W-1:0] res_reg,
    input  logic [DATA_W-1:0] res_data,
    input  logic              flush,
    input  logic              wb_hold,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_reg,
    output logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic              byp_hit1,
    output logic [DATA_W-1:0] byp_data1,
    output logic              byp_hit2,
    output logic [DATA_W-1:0] byp_data2,
    output logic [PW:0]       count
);

    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    wb_state_t             r_state;
    logic                  r_wb_en;
    logic [ADDR_W-1:0]     r_wb_reg;
    logic [DATA_W-1:0]     r_wb_data;

    wb_entry_t [DEPTH-1:0] w_mem;
    logic      [DEPTH-1:0] w_valid;
    logic      [PW-1:0]    w_rd_ptr;
    logic      [PW:0]      w_count;
    wb_entry_t             w_second;
    wb_entry_t             w_in;
    logic                  w_enq;
    logic                  w_deq;
    logic      [PW:0]      w_next_count;

    assign res_ready = (w_count < FULL) && !flush;
    assign w_enq     = res_valid && res_ready && (res_reg != ZERO_REG);
    assign w_deq     = r_wb_en && !wb_hold;
    assign w_in      = '{regidx: res_reg, data: res_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clock),
        .rst_n    (reset),
        .i_flush  (flush),
        .i_enq    (w_enq),
        .i_entry  (w_in),
        .i_deq    (w_deq),
        .o_mem    (w_mem),
        .o_valid  (w_valid),
        .o_rd_ptr (w_rd_ptr),
        .o_count  (w_count),
        .o_second (w_second)
    );

    // Occupancy after this edge, used to decide what the output register shows next.
    always_comb begin
        w_next_count = w_count;
        if (flush) begin
            w_next_count = '0;
        end else begin
            case ({w_enq, w_deq})
                2'b10:   w_next_count = w_count + (PW+1)'(1);
                2'b01:   w_next_count = w_count - (PW+1)'(1);
                default: w_next_count = w_count;
            endcase
        end
    end

    // FSM plus registered write port: the port always mirrors the buffer head, so it
    // loads the entry behind the head on a taken write, or the incoming result when
    // that result becomes the only entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_EMPTY;
            r_wb_en   <= 1'b0;
            r_wb_reg  <= '0;
            r_wb_data <= '0;
        end else if (w_next_count == '0) begin
            r_state <= ST_EMPTY;
            r_wb_en <= 1'b0;
        end else begin
            r_wb_en <= 1'b1;
            r_state <= (wb_hold && r_state != ST_EMPTY) ? ST_STALL : ST_ACTIVE;
            if (w_deq) begin
                if (w_count > (PW+1)'(1)) begin
                    r_wb_reg  <= w_second.regidx;
                    r_wb_data <= w_second.data;
                end else begin
                    r_wb_reg  <= res_reg;
                    r_wb_data <= res_data;
                end
            end else if (w_count == '0) begin
                r_wb_reg  <= res_reg;
                r_wb_data <= res_data;
            end
        end
    end

    assign wb_en   = r_wb_en;
    assign wb_reg  = r_wb_reg;
    assign wb_data = r_wb_data;
    assign count   = w_count;

`ifdef WB_BYPASS_EN
    // Bypass scan from oldest to youngest so the youngest matching entry wins.
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx     = '0;
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            v_idx = w_rd_ptr + PW'(k);
            if (w_valid[v_idx] && rd_reg1 != ZERO_REG && w_mem[v_idx].regidx == rd_reg1) begin
                byp_hit1  = 1'b1;
                byp_data1 = w_mem[v_idx].data;
            end
            if (w_valid[v_idx] && rd_reg2 != ZERO_REG && w_mem[v_idx].regidx == rd_reg2) begin
                byp_hit2  = 1'b1;
                byp_data2 = w_mem[v_idx].data;
            end
        end
    end
`else
    logic w_unused;
    assign w_unused  = ^{w_mem, w_valid, w_rd_ptr, rd_reg1, rd_reg2};
    assign byp_hit1  = 1'b0;
    assign byp_data1 = '0;
    assign byp_hit2  = 1'b0;
    assign byp_data2 = '0;
`endif

endmodule
